dmem_port_arbiter: RTL and testbench

- Shares one single-port 4KB data SRAM wrapper (1024x32 words, byte enables, 1-cycle registered read) between two requesters.
- Master 0 is the CPU data port; master 1 is a DMA/boot-loader port.
- Provides per-master req/gnt handshake, fair round-robin or fixed-priority arbitration, a bounded bus-lock for bursts, and per-master read-data-valid routing.
- Sits between the CPU/loader and the data-memory SRAM wrapper in the SoC top.

---
 rtl/riscv_soc_pkg.sv | 16 +
 rtl/dmem_port_arbiter_rr_arb2.sv | 22 ++
 rtl/dmem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_soc_pkg.sv
// Shared SoC types and constants for the data-memory port arbiter.
package riscv_soc_pkg;

  localparam int DMEM_AW       = 10;
  localparam int DMEM_DW       = 32;
  localparam int DMEM_MAX_LOCK = 16;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    LOCKED_M0 = 2'd1,
    LOCKED_M1 = 2'd2
  } lock_state_e;

  typedef logic master_idx_t;

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-way arbiter: a lone requester always wins; contention goes to master 0
// in fixed mode, otherwise to the master named by ptr.
module rr_arb2
  import riscv_soc_pkg::*;
(
  input  logic [1:0]  req,
  input  logic        fixed_prio,
  input  master_idx_t ptr,
  output logic [1:0]  gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (fixed_prio || (ptr == 1'b0)) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data SRAM between the CPU (m0) and DMA/loader (m1)
// with round-robin or fixed-priority arbitration and bounded burst locking.
//
// state     | meaning
// UNLOCKED  | normal arbitration
// LOCKED_M0 | m0 keeps ownership while it requests with lock, up to MAX_LOCK grants
// LOCKED_M1 | m1 keeps ownership while it requests with lock, up to MAX_LOCK grants
module dmem_port_arbiter
  import riscv_soc_pkg::*;
#(
  parameter int AW        = DMEM_AW,
  parameter int DW        = DMEM_DW,
  parameter int PRIO_MODE = 0,
  parameter int MAX_LOCK  = DMEM_MAX_LOCK
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_be,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_be,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  localparam logic [7:0] MAX_HOLD = 8'(MAX_LOCK);

  lock_state_e state;
  logic [7:0]  hold_cnt;
  master_idx_t rr_ptr;
  logic [1:0]  rvalid_q;

  logic [1:0]  req, lock, arb_req, arb_gnt, gnt;
  logic        locked, forced, lock_win, blk_act, arb_fixed, any_gnt;
  master_idx_t lock_idx, arb_ptr, win;

  assign req      = {m1_req, m0_req};
  assign lock     = {m1_lock, m0_lock};
  assign locked   = (state == LOCKED_M0) || (state == LOCKED_M1);
  assign lock_idx = (state == LOCKED_M1);
  assign forced   = locked && (hold_cnt == MAX_HOLD);
  assign lock_win = locked && !forced && req[lock_idx];
  // On forced release the lock holder must yield to a contending master.
  assign blk_act  = forced && (&req);

  assign arb_req   = lock_win ? (lock_idx ? 2'b10 : 2'b01) : req;
  assign arb_fixed = (PRIO_MODE != 0) && !blk_act;
  assign arb_ptr   = blk_act ? ~lock_idx : rr_ptr;

  rr_arb2 u_arb (
    .req        (arb_req),
    .fixed_prio (arb_fixed),
    .ptr        (arb_ptr),
    .gnt        (arb_gnt)
  );

  assign gnt     = arb_gnt & {2{rst_n}};
  assign any_gnt = |gnt;
  assign win     = gnt[1];
  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];

  assign sram_cs   = any_gnt;
  assign sram_we   = any_gnt && (win ? m1_we : m0_we);
  assign sram_be   = win ? m1_be    : m0_be;
  assign sram_addr = win ? m1_addr  : m0_addr;
  assign sram_din  = win ? m1_wdata : m0_wdata;

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = sram_dout;
  assign m1_rdata  = sram_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNLOCKED;
      hold_cnt <= 8'd0;
      rr_ptr   <= 1'b0;
      rvalid_q <= 2'b00;
    end else begin
      rvalid_q <= gnt & ~{m1_we, m0_we};
      if (any_gnt) rr_ptr <= ~win;
      case (state)
        UNLOCKED: begin
          if (any_gnt && lock[win]) begin
            state    <= win ? LOCKED_M1 : LOCKED_M0;
            hold_cnt <= 8'd1;
          end
        end
        LOCKED_M0, LOCKED_M1: begin
          if (forced || !req[lock_idx] || !lock[lock_idx]) begin
            state    <= UNLOCKED;
            hold_cnt <= 8'd0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state    <= UNLOCKED;
          hold_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with the same masters and
// checks both against a behavioural model of ownership, fairness and memory.
module tb_dmem_port_arbiter;
  localparam int MAXL = 16;

  logic        clk, rst_n;
  logic        m_req [2];
  logic        m_we [2];
  logic [3:0]  m_be [2];
  logic [9:0]  m_addr [2];
  logic [31:0] m_wdata [2];
  logic        m_lock [2];

  logic        rr_gnt0, rr_gnt1, rr_rv0, rr_rv1, rr_cs, rr_we;
  logic [31:0] rr_rd0, rr_rd1, rr_din, rr_dout;
  logic [3:0]  rr_be;
  logic [9:0]  rr_addr;
  logic        fp_gnt0, fp_gnt1, fp_rv0, fp_rv1, fp_cs, fp_we;
  logic [31:0] fp_rd0, fp_rd1, fp_din, fp_dout;
  logic [3:0]  fp_be;
  logic [9:0]  fp_addr;

  logic [31:0] rr_mem [1024];
  logic [31:0] fp_mem [1024];

  // reference model state
  logic [31:0] refmem [2][1024];
  int          owner [2];
  int          hold [2];
  int          last [2];
  logic [1:0]  exp_rv [2];
  logic [31:0] exp_rd [2];
  logic [1:0]  rr_g_seen, fp_g_seen;

  int n_checks = 0;
  int n_errors = 0;

  dmem_port_arbiter #(.PRIO_MODE(0), .MAX_LOCK(MAXL)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m_req[0]), .m0_we(m_we[0]), .m0_be(m_be[0]), .m0_addr(m_addr[0]),
    .m0_wdata(m_wdata[0]), .m0_lock(m_lock[0]),
    .m0_gnt(rr_gnt0), .m0_rvalid(rr_rv0), .m0_rdata(rr_rd0),
    .m1_req(m_req[1]), .m1_we(m_we[1]), .m1_be(m_be[1]), .m1_addr(m_addr[1]),
    .m1_wdata(m_wdata[1]), .m1_lock(m_lock[1]),
    .m1_gnt(rr_gnt1), .m1_rvalid(rr_rv1), .m1_rdata(rr_rd1),
    .sram_cs(rr_cs), .sram_we(rr_we), .sram_be(rr_be), .sram_addr(rr_addr),
    .sram_din(rr_din), .sram_dout(rr_dout)
  );

  dmem_port_arbiter #(.PRIO_MODE(1), .MAX_LOCK(MAXL)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m_req[0]), .m0_we(m_we[0]), .m0_be(m_be[0]), .m0_addr(m_addr[0]),
    .m0_wdata(m_wdata[0]), .m0_lock(m_lock[0]),
    .m0_gnt(fp_gnt0), .m0_rvalid(fp_rv0), .m0_rdata(fp_rd0),
    .m1_req(m_req[1]), .m1_we(m_we[1]), .m1_be(m_be[1]), .m1_addr(m_addr[1]),
    .m1_wdata(m_wdata[1]), .m1_lock(m_lock[1]),
    .m1_gnt(fp_gnt1), .m1_rvalid(fp_rv1), .m1_rdata(fp_rd1),
    .sram_cs(fp_cs), .sram_we(fp_we), .sram_be(fp_be), .sram_addr(fp_addr),
    .sram_din(fp_din), .sram_dout(fp_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM wrappers: registered read, byte-enabled write
  always @(posedge clk) begin
    if (rr_cs) begin
      if (rr_we) begin
        for (int b = 0; b < 4; b++) if (rr_be[b]) rr_mem[rr_addr][8*b +: 8] <= rr_din[8*b +: 8];
      end else rr_dout <= rr_mem[rr_addr];
    end
    if (fp_cs) begin
      if (fp_we) begin
        for (int b = 0; b < 4; b++) if (fp_be[b]) fp_mem[fp_addr][8*b +: 8] <= fp_din[8*b +: 8];
      end else fp_dout <= fp_mem[fp_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_winner(input int p, input logic r0, input logic r1);
    if (!r0 && !r1) return -1;
    if (r0 != r1) return r1 ? 1 : 0;
    if (owner[p] != 0 && hold[p] == MAXL) return 2 - owner[p];
    if (owner[p] != 0) return owner[p] - 1;
    if (p == 1) return 0;
    return 1 - last[p];
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      owner[p] = 0; hold[p] = 0; last[p] = 1; exp_rv[p] = 2'b00; exp_rd[p] = '0;
    end
  endtask

  task automatic model_clock(input int p, input int w);
    int x;
    exp_rv[p] = 2'b00;
    if (w >= 0) begin
      last[p] = w;
      if (m_we[w]) begin
        for (int b = 0; b < 4; b++)
          if (m_be[w][b]) refmem[p][m_addr[w]][8*b +: 8] = m_wdata[w][8*b +: 8];
      end else begin
        exp_rv[p][w] = 1'b1;
        exp_rd[p] = refmem[p][m_addr[w]];
      end
    end
    if (owner[p] != 0) begin
      x = owner[p] - 1;
      if (hold[p] == MAXL || !m_req[x] || !m_lock[x]) begin
        owner[p] = 0; hold[p] = 0;
      end else hold[p]++;
    end else if (w >= 0 && m_lock[w]) begin
      owner[p] = w + 1; hold[p] = 1;
    end
  endtask

  task automatic step();
    int w [2];
    logic [1:0]  og, orv;
    logic [31:0] ord0, ord1;
    logic        ocs, owe;
    logic [9:0]  oad;
    string       nm;
    #1;
    for (int p = 0; p < 2; p++) begin
      w[p] = exp_winner(p, m_req[0], m_req[1]);
      if (p == 0) begin
        og = {rr_gnt1, rr_gnt0}; orv = {rr_rv1, rr_rv0}; ord0 = rr_rd0; ord1 = rr_rd1;
        ocs = rr_cs; owe = rr_we; oad = rr_addr; nm = "rr"; rr_g_seen = og;
      end else begin
        og = {fp_gnt1, fp_gnt0}; orv = {fp_rv1, fp_rv0}; ord0 = fp_rd0; ord1 = fp_rd1;
        ocs = fp_cs; owe = fp_we; oad = fp_addr; nm = "fp"; fp_g_seen = og;
      end
      check({nm, "_gnt"}, 32'(og), (w[p] < 0) ? 32'd0 : (w[p] == 0 ? 32'd1 : 32'd2));
      check({nm, "_sram_cs"}, 32'(ocs), 32'(w[p] >= 0));
      if (w[p] >= 0) begin
        check({nm, "_sram_addr"}, 32'(oad), 32'(m_addr[w[p]]));
        check({nm, "_sram_we"}, 32'(owe), 32'(m_we[w[p]]));
      end
      check({nm, "_rvalid"}, 32'(orv), 32'(exp_rv[p]));
      if (exp_rv[p][0]) check({nm, "_rdata0"}, ord0, exp_rd[p]);
      if (exp_rv[p][1]) check({nm, "_rdata1"}, ord1, exp_rd[p]);
    end
    @(posedge clk);
    for (int p = 0; p < 2; p++) model_clock(p, w[p]);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 0; m_we[i] = 0; m_be[i] = 4'hF; m_addr[i] = '0; m_wdata[i] = '0; m_lock[i] = 0;
    end
  endtask

  task automatic set_m(input int i, input logic req, input logic we, input logic [3:0] be,
                       input logic [9:0] addr, input logic [31:0] wd, input logic lk);
    m_req[i] = req; m_we[i] = we; m_be[i] = be; m_addr[i] = addr; m_wdata[i] = wd; m_lock[i] = lk;
  endtask

  int streak, max_streak, fp_m1_cnt;

  initial begin
    logic [31:0] v;
    rst_n = 1'b0;
    rr_dout = '0; fp_dout = '0;
    idle_inputs();
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      rr_mem[i] = v; fp_mem[i] = v; refmem[0][i] = v; refmem[1][i] = v;
    end
    rr_mem[4] = 32'hDEADBEEF; fp_mem[4] = 32'hDEADBEEF;
    refmem[0][4] = 32'hDEADBEEF; refmem[1][4] = 32'hDEADBEEF;
    rr_mem[16] = 32'hA5A5A5A5; fp_mem[16] = 32'hA5A5A5A5;
    refmem[0][16] = 32'hA5A5A5A5; refmem[1][16] = 32'hA5A5A5A5;
    model_reset();

    // reset: requests present but no grant may leak out
    m_req[0] = 1; m_req[1] = 1;
    @(negedge clk); #1;
    check("rst_gnt_rr", 32'({rr_gnt1, rr_gnt0}), 32'd0);
    check("rst_gnt_fp", 32'({fp_gnt1, fp_gnt0}), 32'd0);
    check("rst_cs", 32'({rr_cs, fp_cs}), 32'd0);
    check("rst_rvalid", 32'({rr_rv1, rr_rv0, fp_rv1, fp_rv0}), 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // single read of 0xDEADBEEF by m0
    set_m(0, 1, 0, 4'hF, 10'h004, 32'h0, 0);
    step();
    idle_inputs();
    #1;
    check("rd_deadbeef", rr_rd0, 32'hDEADBEEF);
    check("rd_m1_quiet", 32'(rr_rv1), 32'd0);
    step();

    // both masters read every cycle
    for (int c = 0; c < 8; c++) begin
      set_m(0, 1, 0, 4'hF, 10'($urandom_range(0, 1023)), 32'h0, 0);
      set_m(1, 1, 0, 4'hF, 10'($urandom_range(0, 1023)), 32'h0, 0);
      step();
    end
    // m0 drops: m1 must be granted the same cycle in fixed-priority mode
    m_req[0] = 0;
    step();
    idle_inputs();
    step();

    // m1 locked burst of writes against a reading m0
    streak = 0; max_streak = 0; fp_m1_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      set_m(0, 1, 0, 4'hF, 10'(c), 32'h0, 0);
      set_m(1, 1, 1, 4'hF, 10'(256 + c), $urandom, 1);
      step();
      if (rr_g_seen[1]) streak++; else streak = 0;
      if (streak > max_streak) max_streak = streak;
      if (fp_g_seen[1]) fp_m1_cnt++;
    end
    check("rr_lock_streak", 32'(max_streak), 32'(MAXL));
    check("fp_m1_starved", 32'(fp_m1_cnt), 32'd0);
    idle_inputs();
    step();

    // m0 locked burst in fixed-priority mode must still yield once
    fp_m1_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      set_m(0, 1, 0, 4'hF, 10'(c), 32'h0, 1);
      set_m(1, 1, 0, 4'hF, 10'(512 + c), 32'h0, 0);
      step();
      if (fp_g_seen[1]) fp_m1_cnt++;
    end
    check("fp_forced_yield", 32'(fp_m1_cnt), 32'd1);
    idle_inputs();
    step();

    // partial write then read-back
    set_m(0, 1, 1, 4'b0011, 10'h010, 32'h12345678, 0);
    step();
    set_m(0, 1, 0, 4'hF, 10'h010, 32'h0, 0);
    step();
    idle_inputs();
    #1;
    check("be_readback", rr_rd0, 32'hA5A55678);
    step();

    // reset lands right after an accepted read
    set_m(0, 1, 0, 4'hF, 10'h004, 32'h0, 0);
    #1;
    check("pre_rst_gnt", 32'(rr_gnt0), 32'd1);
    @(posedge clk);
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check("rst_drop_rv", 32'({rr_rv1, rr_rv0, fp_rv1, fp_rv0}), 32'd0);
    @(negedge clk);
    check("rst_hold_rv", 32'({rr_rv1, rr_rv0, fp_rv1, fp_rv0}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_m(0, 1, 0, 4'hF, 10'h001, 32'h0, 0);
    set_m(1, 1, 0, 4'hF, 10'h002, 32'h0, 0);
    #1;
    check("post_rst_m0_first", 32'({rr_gnt1, rr_gnt0}), 32'd1);
    step();
    idle_inputs();
    step();

    // randomized traffic
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 2; i++)
        set_m(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
              10'($urandom_range(0, 31)), $urandom, $urandom_range(0, 15) != 0);
      step();
    end
    idle_inputs();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
